// File: rtl/shift_div_seq_ctrl.sv
// shift_div_seq_ctrl: sequencer for an external 10-bit restoring-division datapath.
// Drives load / clear / shift / subtract-commit strobes for the A (remainder), Q (quotient)
// and B (divisor) registers, counts iterations and handshakes with the host.
// Optional feature macro: DIVZERO_CHK_EN adds the div_zero input and err output, and
// short-circuits a zero-divisor request straight to DONE.
module shift_div_seq_ctrl #(
   parameter int unsigned N  = 10,
   parameter int unsigned CW = 4
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          start,
   input  logic          sign_bit,
`ifdef DIVZERO_CHK_EN
   input  logic          div_zero,
   output logic          err,
`endif
   output logic          busy,
   output logic          done,
   output logic          ld_regs,
   output logic          sclr_a,
   output logic          shl,
   output logic          sub_ld,
   output logic          qset,
   output logic [CW-1:0] cnt
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StShift = 3'd2,
      StEval  = 3'd3,
      StDone  = 3'd4
   } state_e;

   localparam logic [CW-1:0] CntLast = CW'(N - 1);
   localparam logic [CW-1:0] CntMax  = CW'(N);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

`ifdef DIVZERO_CHK_EN
   logic err_q, err_d;
   logic zero_req;

   // A start with a zero divisor bypasses the datapath entirely
   assign zero_req = start & div_zero;
`endif

   // State, counter and error flag registers
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
`ifdef DIVZERO_CHK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef DIVZERO_CHK_EN
         err_q   <= err_d;
`endif
      end
   end

   // Next-state, iteration counter and error flag update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef DIVZERO_CHK_EN
      err_d   = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
`ifdef DIVZERO_CHK_EN
               if (zero_req) begin
                  state_d = StDone;
                  err_d   = 1'b1;
               end else begin
                  state_d = StLoad;
                  err_d   = 1'b0;
               end
`else
               state_d = StLoad;
`endif
            end
         end
         StLoad: begin
            cnt_d   = '0;
            state_d = StShift;
         end
         StShift: begin
            state_d = StEval;
         end
         StEval: begin
            // Saturate so cnt can never wrap past N
            if (cnt_q != CntMax) begin
               cnt_d = cnt_q + 1'b1;
            end
            state_d = (cnt_q == CntLast) ? StDone : StShift;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Moore strobes from the state register; subtract-commit is Mealy on sign_bit in EVAL
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      ld_regs = 1'b0;
      sclr_a  = 1'b0;
      shl     = 1'b0;
      sub_ld  = 1'b0;
      qset    = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
         end
         StLoad: begin
            busy    = 1'b1;
            ld_regs = 1'b1;
            sclr_a  = 1'b1;
         end
         StShift: begin
            busy = 1'b1;
            shl  = 1'b1;
         end
         StEval: begin
            busy   = 1'b1;
            // Non-negative A - B means the divisor fits: commit and set the quotient bit
            sub_ld = ~sign_bit;
            qset   = ~sign_bit;
         end
         StDone: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign cnt = cnt_q;

`ifdef DIVZERO_CHK_EN
   assign err = err_q;
`endif

endmodule
